// File: rtl/pwm_reg_write_scheduler.sv
// Arbitrates two SPI write requesters onto one register-bank write port.
// Cycle-count writes made while the PWM runs are staged and committed at a period boundary.
module pwm_reg_write_scheduler #(
    parameter int NUM_REGS  = 10,
    parameter int ADDR_CTRL = 1,
    parameter int ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [7:0]        data_a,
    input  logic              req_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [7:0]        data_b,
    output logic              ack_a,
    output logic              err_a,
    output logic              ack_b,
    output logic              err_b,
    input  logic              pwm_running,
    input  logic              period_end,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              staged_pending,
    output logic              draining
);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t              state_q;
    logic                lastGrantB_q;
    logic                ack_a_q, err_a_q, ack_b_q, err_b_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [7:0]          wr_data_q;
    logic                staged_pending_q;
    logic [NUM_REGS-1:0] valid_q;
    logic [7:0]          shadow_q [NUM_REGS];

    logic                eligA, eligB, grantA, grantB;
    logic [ADDR_W-1:0]   selAddr;
    logic [7:0]          selData;
    logic                addrBad, stageIt, startDrain;
    logic                drainFound;
    logic [ADDR_W-1:0]   drainIdx;
    logic [NUM_REGS-1:0] validLeft;

    // A requester whose ack/err is on the wire this cycle is still holding the old request.
    always_comb begin
        eligA      = req_a & ~ack_a_q & ~err_a_q;
        eligB      = req_b & ~ack_b_q & ~err_b_q;
        grantA     = eligA & (~eligB | lastGrantB_q);
        grantB     = eligB & ~grantA;
        selAddr    = grantA ? addr_a : addr_b;
        selData    = grantA ? data_a : data_b;
        addrBad    = (selAddr == '0) || ({1'b0, selAddr} >= (ADDR_W+1)'(NUM_REGS));
        stageIt    = pwm_running && (selAddr != ADDR_W'(ADDR_CTRL)) && (selAddr >= ADDR_W'(2));
        startDrain = (|valid_q) & (period_end | ~pwm_running);
    end

    // Descending scan so the lowest valid address is the one left selected.
    always_comb begin
        drainFound = 1'b0;
        drainIdx   = '0;
        for (int i = NUM_REGS - 1; i >= 2; i--) begin
            if (valid_q[i]) begin
                drainFound = 1'b1;
                drainIdx   = ADDR_W'(i);
            end
        end
        validLeft = valid_q;
        if (drainFound) validLeft[drainIdx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            lastGrantB_q     <= 1'b1;
            ack_a_q          <= 1'b0;
            err_a_q          <= 1'b0;
            ack_b_q          <= 1'b0;
            err_b_q          <= 1'b0;
            wr_en_q          <= 1'b0;
            wr_addr_q        <= '0;
            wr_data_q        <= '0;
            staged_pending_q <= 1'b0;
            valid_q          <= '0;
            for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
        end else begin
            ack_a_q          <= 1'b0;
            err_a_q          <= 1'b0;
            ack_b_q          <= 1'b0;
            err_b_q          <= 1'b0;
            wr_en_q          <= 1'b0;
            staged_pending_q <= |valid_q;
            case (state_q)
                IDLE: begin
                    if (startDrain) begin
                        state_q <= DRAIN;
                    end else if (grantA || grantB) begin
                        lastGrantB_q <= grantB;
                        if (addrBad) begin
                            err_a_q <= grantA;
                            err_b_q <= grantB;
                        end else begin
                            ack_a_q <= grantA;
                            ack_b_q <= grantB;
                            if (stageIt) begin
                                shadow_q[selAddr] <= selData;
                                valid_q[selAddr]  <= 1'b1;
                            end else begin
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= selAddr;
                                wr_data_q <= selData;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (drainFound) begin
                        wr_en_q           <= 1'b1;
                        wr_addr_q         <= drainIdx;
                        wr_data_q         <= shadow_q[drainIdx];
                        valid_q[drainIdx] <= 1'b0;
                        if (validLeft == '0) state_q <= IDLE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_a          = ack_a_q;
    assign err_a          = err_a_q;
    assign ack_b          = ack_b_q;
    assign err_b          = err_b_q;
    assign wr_en          = wr_en_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign staged_pending = staged_pending_q;
    assign draining       = (state_q == DRAIN);

endmodule

// File: tb/tb_pwm_reg_write_scheduler.sv
// Directed bench for pwm_reg_write_scheduler: arbitration, access policy,
// staging, period-boundary drain and reset mid-drain.
module tb_pwm_reg_write_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a, req_b;
    logic [3:0] addr_a, addr_b;
    logic [7:0] data_a, data_b;
    logic       ack_a, err_a, ack_b, err_b;
    logic       pwm_running, period_end;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       staged_pending, draining;

    int checksTotal  = 0;
    int checksPassed = 0;

    pwm_reg_write_scheduler #(.NUM_REGS(10), .ADDR_CTRL(1), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .addr_a(addr_a), .data_a(data_a),
        .req_b(req_b), .addr_b(addr_b), .data_b(data_b),
        .ack_a(ack_a), .err_a(err_a), .ack_b(ack_b), .err_b(err_b),
        .pwm_running(pwm_running), .period_end(period_end),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .staged_pending(staged_pending), .draining(draining)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the active edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rqA, input logic [3:0] adA, input logic [7:0] dtA,
                                 input logic rqB, input logic [3:0] adB, input logic [7:0] dtB);
        req_a  = rqA;
        addr_a = adA;
        data_a = dtA;
        req_b  = rqB;
        addr_b = adB;
        data_b = dtB;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checksTotal++;
        assert (observed === expected) checksPassed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic expectOut(input string tag, input logic eAckA, input logic eErrA,
                             input logic eAckB, input logic eErrB, input logic eWr,
                             input logic [3:0] eAddr, input logic [7:0] eData,
                             input logic eStaged, input logic eDrain);
        checkOutput({tag, ".ack_a"}, 8'(ack_a), 8'(eAckA));
        checkOutput({tag, ".err_a"}, 8'(err_a), 8'(eErrA));
        checkOutput({tag, ".ack_b"}, 8'(ack_b), 8'(eAckB));
        checkOutput({tag, ".err_b"}, 8'(err_b), 8'(eErrB));
        checkOutput({tag, ".wr_en"}, 8'(wr_en), 8'(eWr));
        checkOutput({tag, ".wr_addr"}, 8'(wr_addr), 8'(eAddr));
        checkOutput({tag, ".wr_data"}, wr_data, eData);
        checkOutput({tag, ".staged_pending"}, 8'(staged_pending), 8'(eStaged));
        checkOutput({tag, ".draining"}, 8'(draining), 8'(eDrain));
    endtask

    initial begin
        rst_n       = 1'b0;
        pwm_running = 1'b0;
        period_end  = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        expectOut("reset", 0, 0, 0, 0, 0, 4'h0, 8'h00, 0, 0);
        rst_n = 1'b1;

        // Access policy: control write, read-only ID register, out-of-range address.
        applyStimulus(1, 4'd1, 8'h01, 0, 0, 0);
        tick();
        expectOut("ctrl_write", 1, 0, 0, 0, 1, 4'd1, 8'h01, 0, 0);
        applyStimulus(1, 4'd0, 8'h55, 0, 0, 0);
        tick();
        expectOut("id_write_idle", 0, 0, 0, 0, 0, 4'd1, 8'h01, 0, 0);
        tick();
        expectOut("id_write_err", 0, 1, 0, 0, 0, 4'd1, 8'h01, 0, 0);
        applyStimulus(0, 0, 0, 1, 4'd12, 8'h77);
        tick();
        expectOut("range_err", 0, 0, 0, 1, 0, 4'd1, 8'h01, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        expectOut("idle1", 0, 0, 0, 0, 0, 4'd1, 8'h01, 0, 0);

        // Round-robin arbitration from a fresh reset.
        rst_n = 1'b0;
        tick();
        expectOut("reset2", 0, 0, 0, 0, 0, 4'h0, 8'h00, 0, 0);
        rst_n = 1'b1;
        applyStimulus(1, 4'd3, 8'hAA, 1, 4'd4, 8'hBB);
        tick();
        expectOut("tie_a_first", 1, 0, 0, 0, 1, 4'd3, 8'hAA, 0, 0);
        applyStimulus(1, 4'd6, 8'h66, 1, 4'd4, 8'hBB);
        tick();
        expectOut("then_b", 0, 0, 1, 0, 1, 4'd4, 8'hBB, 0, 0);
        applyStimulus(1, 4'd6, 8'h66, 1, 4'd7, 8'h77);
        tick();
        expectOut("alt_a", 1, 0, 0, 0, 1, 4'd6, 8'h66, 0, 0);
        applyStimulus(0, 0, 0, 1, 4'd7, 8'h77);
        tick();
        expectOut("alt_b", 0, 0, 1, 0, 1, 4'd7, 8'h77, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        expectOut("idle2", 0, 0, 0, 0, 0, 4'd7, 8'h77, 0, 0);
        applyStimulus(1, 4'd8, 8'h88, 0, 0, 0);
        tick();
        expectOut("a_alone", 1, 0, 0, 0, 1, 4'd8, 8'h88, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        expectOut("idle3", 0, 0, 0, 0, 0, 4'd8, 8'h88, 0, 0);
        applyStimulus(1, 4'd9, 8'h99, 1, 4'd2, 8'h22);
        tick();
        expectOut("tie_b_wins", 0, 0, 1, 0, 1, 4'd2, 8'h22, 0, 0);
        applyStimulus(1, 4'd9, 8'h99, 0, 0, 0);
        tick();
        expectOut("a_after_b", 1, 0, 0, 0, 1, 4'd9, 8'h99, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        expectOut("idle4", 0, 0, 0, 0, 0, 4'd9, 8'h99, 0, 0);

        // Staging while the PWM runs, last write to an address wins.
        pwm_running = 1'b1;
        applyStimulus(1, 4'd2, 8'h11, 0, 0, 0);
        tick();
        expectOut("stage_2_11", 1, 0, 0, 0, 0, 4'd9, 8'h99, 0, 0);
        applyStimulus(0, 0, 0, 1, 4'd5, 8'h22);
        tick();
        expectOut("stage_5_22", 0, 0, 1, 0, 0, 4'd9, 8'h99, 1, 0);
        applyStimulus(1, 4'd2, 8'h33, 0, 0, 0);
        tick();
        expectOut("stage_2_33", 1, 0, 0, 0, 0, 4'd9, 8'h99, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        expectOut("staged_idle", 0, 0, 0, 0, 0, 4'd9, 8'h99, 1, 0);

        // Period boundary drain with B stalled behind it.
        period_end = 1'b1;
        tick();
        expectOut("drain_enter", 0, 0, 0, 0, 0, 4'd9, 8'h99, 1, 1);
        period_end = 1'b0;
        applyStimulus(0, 0, 0, 1, 4'd1, 8'h5A);
        tick();
        expectOut("drain_addr2", 0, 0, 0, 0, 1, 4'd2, 8'h33, 1, 1);
        tick();
        expectOut("drain_addr5", 0, 0, 0, 0, 1, 4'd5, 8'h22, 1, 0);
        tick();
        expectOut("b_after_drain", 0, 0, 1, 0, 1, 4'd1, 8'h5A, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        expectOut("idle5", 0, 0, 0, 0, 0, 4'd1, 8'h5A, 0, 0);

        // Control register bypasses staging even while running.
        applyStimulus(1, 4'd1, 8'h00, 0, 0, 0);
        tick();
        expectOut("ctrl_running", 1, 0, 0, 0, 1, 4'd1, 8'h00, 0, 0);
        applyStimulus(1, 4'd3, 8'h44, 0, 0, 0);
        tick();
        expectOut("ctrl_gap", 0, 0, 0, 0, 0, 4'd1, 8'h00, 0, 0);
        tick();
        expectOut("stage_3_44", 1, 0, 0, 0, 0, 4'd1, 8'h00, 0, 0);
        applyStimulus(0, 0, 0, 1, 4'd6, 8'h66);
        tick();
        expectOut("stage_6_66", 0, 0, 1, 0, 0, 4'd1, 8'h00, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        expectOut("staged_idle2", 0, 0, 0, 0, 0, 4'd1, 8'h00, 1, 0);

        // PWM stop triggers the drain; reset part-way through discards the rest.
        pwm_running = 1'b0;
        tick();
        expectOut("stop_drain", 0, 0, 0, 0, 0, 4'd1, 8'h00, 1, 1);
        tick();
        expectOut("stop_addr3", 0, 0, 0, 0, 1, 4'd3, 8'h44, 1, 1);
        rst_n = 1'b0;
        tick();
        expectOut("mid_reset", 0, 0, 0, 0, 0, 4'd0, 8'h00, 0, 0);
        rst_n = 1'b1;
        tick();
        expectOut("post_reset1", 0, 0, 0, 0, 0, 4'd0, 8'h00, 0, 0);
        tick();
        expectOut("post_reset2", 0, 0, 0, 0, 0, 4'd0, 8'h00, 0, 0);

        $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/pwm_reg_write_scheduler.md
# pwm_reg_write_scheduler

Arbitrates register-file write requests from the two SPI front-ends (own-clock and sampled) onto a single write port of the device register bank. Enforces the access policy for PWM configuration registers. Writes to cycle-count registers made while the PWM is running are staged in a shadow bank and committed only at a PWM period boundary, so the 32-bit high/freq words never change mid-period. Sits between the SPI slaves and the device register bank, alongside the PWM generator.

## Interface
Parameters:
- NUM_REGS, 10, number of device registers; address 0 is the read-only ID register.
- ADDR_CTRL, 1, PWM control register address; never staged.
- ADDR_W, 4, address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_a / req_b  in  1  write request, level; held with addr/data stable until ack or err.
- addr_a / addr_b  in  ADDR_W  target register address.
- data_a / data_b  in  8  write data.
- ack_a / ack_b  out  1  one-cycle pulse: request accepted (written or staged).
- err_a / err_b  out  1  one-cycle pulse: request rejected (addr 0 or addr ≥ NUM_REGS).
- pwm_running  in  1  PWM generator active.
- period_end  in  1  one-cycle pulse on the last clk of a PWM period.
- wr_en  out  1  register-bank write strobe.
- wr_addr  out  ADDR_W  register-bank write address.
- wr_data  out  8  register-bank write data.
- staged_pending  out  1  at least one shadow byte is valid.
- draining  out  1  FSM is in DRAIN.

## Operation
- Shadow bank: one 8-bit byte and one valid bit per address 2..NUM_REGS-1.
- FSM has two states, IDLE and DRAIN.
- IDLE arbitration:
  - Eligible requester: req_x=1 and ack_x/err_x not high this cycle.
  - Both eligible: round-robin, granting the requester not granted last.
  - last_grant resets to B, so A wins the first tie.
- Granted request, by address:
  - addr 0 or ≥ NUM_REGS: err_x next cycle; no write; shadow unchanged.
  - addr = ADDR_CTRL: direct write (wr_en, wr_addr, wr_data) plus ack_x next cycle, regardless of pwm_running.
  - addr 2..NUM_REGS-1 with pwm_running=0: direct write plus ack_x.
  - addr 2..NUM_REGS-1 with pwm_running=1: store in the shadow byte and set valid; ack_x; no wr_en. A later staged write to the same address overwrites it (last wins).
- IDLE → DRAIN when staged_pending=1 and either:
  - period_end=1, or
  - pwm_running=0 (PWM stopped with staged bytes).
- In the transition cycle no grant is made; drain takes priority over requests.
- DRAIN:
  - One wr_en per cycle, valid bytes in ascending address order, invalid addresses skipped.
  - Each byte's valid bit is cleared as it is written.
  - No grants; requesters stall with req held.
- DRAIN → IDLE after the last valid byte is written. Drain length equals the valid count at entry.
- period_end with no staged bytes: no action.

## Timing
- All outputs registered.
- Reset values: all outputs 0; all valid bits 0; state IDLE; last_grant=B.
- Reset mid-drain discards remaining staged bytes and issues no further wr_en.
- Latency: req sampled at cycle N → ack/err and wr_en (if any) at N+1.
- Per-requester throughput: 1 write per 2 cycles. Two contending requesters alternate, one grant per cycle overall.
- Drain start: period_end at cycle N → first drain wr_en at N+2 (draining=1 from N+1). Then one byte per cycle.
- staged_pending falls in the cycle after the final drain write.
- A request arriving in the same cycle as a drain-triggering period_end is granted only after DRAIN exits. If pwm_running is still 1, a write to a cycle register is staged again.
- wr_en and ack_x for the same request appear in the same cycle.
- wr_addr and wr_data hold their last values when wr_en=0.

## Test plan
- Reset, then A writes addr 1 = 0x01 → ack_a and wr_en/addr1/0x01 one cycle later; err_a writing addr 0 = 0x55, no wr_en; err_b for addr 12.
- A and B both request from reset, addr 3/0xAA and addr 4/0xBB held → A granted first, B next cycle. A re-requests → B/A alternate.
- pwm_running=1, write addrs 2,5,2 = 0x11,0x22,0x33 → three acks, no wr_en. period_end → drain writes addr2=0x33 then addr5=0x22 on consecutive cycles; staged_pending falls.
- During the drain, B requests addr 1 → no ack until drain ends, then ack_b with wr_en.
- Staged bytes pending, pwm_running falls with no period_end → drain starts immediately. rst_n low mid-drain → remaining bytes never written; all outputs 0.
- pwm_running=1, write addr 1 = 0x00 → immediate wr_en (not staged).
